// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: requester-side and UART-side handshake bundle for uart_tx_arb
interface uart_tx_arb_if #(
  parameter int NUM_REQ = 4
);
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [2:0]           grant_id;
  logic                 busy;
  logic                 timeout_pulse;
  modport master (
    output req_data, req_valid, req_last, tx_ready,
    input  req_ready, tx_data, tx_valid, grant_id, busy, timeout_pulse
  );
  modport slave (
    input  req_data, req_valid, req_last, tx_ready,
    output req_ready, tx_data, tx_valid, grant_id, busy, timeout_pulse
  );
endinterface

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: packet-level round-robin arbiter sharing one UART tx byte channel
module uart_tx_arb #(
  parameter int          NUM_REQ     = 4,
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input logic          sys_clk,
  input logic          sys_rst,
  uart_tx_arb_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t      state;
  logic [2:0]  last_id, win;
  logic [15:0] cnt, cnt_inc;
  logic [7:0]  valid8, last8;
  logic [63:0] data64;
  logic        own_valid, fire;
  int          s;
  assign valid8    = 8'(bus.req_valid);
  assign last8     = 8'(bus.req_last);
  assign data64    = 64'(bus.req_data);
  assign own_valid = state == GRANT && valid8[bus.grant_id];
  assign cnt_inc   = &cnt ? cnt : cnt + 16'd1;
  assign fire      = TIMEOUT_CYC != 16'd0 && !own_valid && cnt_inc == TIMEOUT_CYC;
  assign bus.tx_valid  = own_valid;
  assign bus.tx_data   = state == GRANT ? data64[{bus.grant_id, 3'b000} +: 8] : 8'h00;
  assign bus.req_ready = (state == GRANT && bus.tx_ready) ? NUM_REQ'(8'b1 << bus.grant_id) : '0;
  // round-robin pick: nearest valid requester after last_id (descending scan so the nearest wins)
  always_comb begin
    win = '0;
    s = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      s = int'(last_id) + i;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      if (valid8[3'(s)]) win = 3'(s);
    end
  end
  // grant on any request, release on the last beat or after the owner idles too long
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      state             <= IDLE;
      bus.grant_id      <= '0;
      bus.busy          <= 1'b0;
      bus.timeout_pulse <= 1'b0;
      last_id           <= 3'(NUM_REQ - 1);
      cnt               <= '0;
    end else begin
      bus.timeout_pulse <= 1'b0;
      if (state == IDLE) begin
        cnt <= '0;
        if (|bus.req_valid) begin
          state        <= GRANT;
          bus.busy     <= 1'b1;
          bus.grant_id <= win;
        end
      end else if ((own_valid && bus.tx_ready && last8[bus.grant_id]) || fire) begin
        state             <= IDLE;
        bus.busy          <= 1'b0;
        last_id           <= bus.grant_id;
        bus.timeout_pulse <= fire;
      end else
        cnt <= own_valid ? '0 : cnt_inc;
    end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: table vectors, directed corner cases and random traffic against a packet-level model
module tb_uart_tx_arb;
  localparam int N  = 4;
  localparam int TO = 10;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int total = 0, bad = 0;
  uart_tx_arb_if #(.NUM_REQ(N)) ia ();
  uart_tx_arb_if #(.NUM_REQ(N)) ib ();
  uart_tx_arb #(.NUM_REQ(N), .TIMEOUT_CYC(16'(TO))) dut_a (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(ia));
  uart_tx_arb #(.NUM_REQ(N), .TIMEOUT_CYC(16'd0))   dut_b (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(ib));
  // free-running system clock
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [3:0]  valid, last;
    logic [31:0] data;
    logic        rdy;
    logic [16:0] exp;
  } vec_t;
  vec_t vec[16];

  int m_owner, m_last, m_idle;
  logic m_busy, m_pulse;
  logic [3:0] cv, cl, acc;
  logic cr;
  int bc[4];

  function automatic vec_t mk(logic [3:0] v, logic [3:0] l, logic [31:0] d, logic r,
                              logic tv, logic [7:0] td, logic [3:0] rr, logic [2:0] g, logic b);
    vec_t x;
    x.valid = v; x.last = l; x.data = d; x.rdy = r; x.exp = {tv, td, rr, g, b};
    return x;
  endfunction

  function automatic logic [17:0] act_a();
    return {ia.tx_valid, ia.tx_data, ia.req_ready, ia.grant_id, ia.busy, ia.timeout_pulse};
  endfunction

  function automatic logic [17:0] m_exp();
    logic [7:0] d;
    logic tv;
    logic [3:0] rr;
    d  = m_busy ? ia.req_data[m_owner*8 +: 8] : 8'h00;
    tv = m_busy && ia.req_valid[m_owner];
    rr = (m_busy && ia.tx_ready) ? 4'(1 << m_owner) : 4'h0;
    return {tv, d, rr, 3'(m_owner), m_busy, m_pulse};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic m_reset();
    m_owner = 0; m_last = N - 1; m_idle = 0; m_busy = 0; m_pulse = 0;
  endtask

  // one clock of the packet-level rules: pick next owner, end on last beat, or release on idle timeout
  task automatic m_step();
    logic found;
    found = 0;
    m_pulse = 0;
    if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (!found && cv[c]) begin
          found = 1; m_owner = c; m_busy = 1; m_idle = 0;
        end
      end
    end else if (cv[m_owner] && cr && cl[m_owner]) begin
      m_busy = 0; m_last = m_owner;
    end else if (cv[m_owner]) m_idle = 0;
    else begin
      m_idle++;
      if (m_idle >= TO) begin
        m_busy = 0; m_last = m_owner; m_pulse = 1;
      end
    end
  endtask

  task automatic cyc_a();
    @(negedge sys_clk);
    chk("model", 64'(act_a()), 64'(m_exp()));
    cv = ia.req_valid; cl = ia.req_last; cr = ia.tx_ready;
    acc = (m_busy && cr) ? (cv & 4'(1 << m_owner)) : 4'h0;
  endtask

  task automatic cyc_b();
    @(posedge sys_clk);
    m_step();
    #1;
  endtask

  task automatic cyc();
    cyc_a();
    cyc_b();
  endtask

  task automatic do_reset();
    ia.req_valid = '0; ia.req_last = '0; ia.req_data = '0; ia.tx_ready = 1'b0;
    sys_rst = 1'b1;
    m_reset();
    acc = '0;
    @(posedge sys_clk);
    #1;
    chk("reset", 64'(act_a()), 64'd0);
    sys_rst = 1'b0;
  endtask

  task automatic all_in();
    ia.req_valid = 4'hF;
    ia.tx_ready = 1'b1;
    for (int r = 0; r < N; r++) begin
      ia.req_data[r*8 +: 8] = 8'(r * 16 + bc[r]);
      ia.req_last[r] = (bc[r] == 1);
    end
  endtask

  initial begin
    logic [2:0] ord[5];
    int no, t, errs;
    logic pb;
    logic [3:0] rv, rl;
    logic [7:0] rd[4];
    int pause[4];
    vec[0]  = mk(4'b0100, 4'b0000, 32'h0041_0000, 1, 0, 8'h00, 4'b0000, 3'd0, 0);
    vec[1]  = mk(4'b0100, 4'b0000, 32'h0041_0000, 1, 1, 8'h41, 4'b0100, 3'd2, 1);
    vec[2]  = mk(4'b0100, 4'b0000, 32'h0042_0000, 1, 1, 8'h42, 4'b0100, 3'd2, 1);
    vec[3]  = mk(4'b0100, 4'b0100, 32'h0043_0000, 1, 1, 8'h43, 4'b0100, 3'd2, 1);
    vec[4]  = mk(4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 8'h00, 4'b0000, 3'd2, 0);
    vec[5]  = mk(4'b0010, 4'b0000, 32'h0000_5500, 1, 0, 8'h00, 4'b0000, 3'd2, 0);
    vec[6]  = mk(4'b0010, 4'b0000, 32'h0000_5500, 1, 1, 8'h55, 4'b0010, 3'd1, 1);
    vec[7]  = mk(4'b1011, 4'b1001, 32'h3300_6611, 1, 1, 8'h66, 4'b0010, 3'd1, 1);
    vec[8]  = mk(4'b1011, 4'b1001, 32'h3300_7711, 0, 1, 8'h77, 4'b0000, 3'd1, 1);
    vec[9]  = mk(4'b1011, 4'b1001, 32'h3300_7711, 0, 1, 8'h77, 4'b0000, 3'd1, 1);
    vec[10] = mk(4'b1011, 4'b1011, 32'h3300_7711, 1, 1, 8'h77, 4'b0010, 3'd1, 1);
    vec[11] = mk(4'b1001, 4'b1001, 32'h3300_0011, 1, 0, 8'h00, 4'b0000, 3'd1, 0);
    vec[12] = mk(4'b1001, 4'b1001, 32'h3300_0011, 1, 1, 8'h33, 4'b1000, 3'd3, 1);
    vec[13] = mk(4'b0001, 4'b0001, 32'h0000_0011, 1, 0, 8'h00, 4'b0000, 3'd3, 0);
    vec[14] = mk(4'b0001, 4'b0001, 32'h0000_0011, 1, 1, 8'h11, 4'b0001, 3'd0, 1);
    vec[15] = mk(4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 8'h00, 4'b0000, 3'd0, 0);
    ib.req_valid = '0; ib.req_last = '0; ib.req_data = '0; ib.tx_ready = 1'b0;
    do_reset();
    chk("reset_b", 64'({ib.tx_valid, ib.tx_data, ib.req_ready, ib.grant_id, ib.busy, ib.timeout_pulse}), 64'd0);

    // table: single packet from requester 2, then owner 1 with tx_ready stalls
    for (int i = 0; i < 16; i++) begin
      ia.req_valid = vec[i].valid; ia.req_last = vec[i].last;
      ia.req_data = vec[i].data; ia.tx_ready = vec[i].rdy;
      cyc_a();
      chk($sformatf("vec%0d", i), 64'(act_a() >> 1), 64'(vec[i].exp));
      cyc_b();
    end

    // all four requesters with 2-byte packets from reset: grants 0,1,2,3,0
    do_reset();
    bc = '{default: 0};
    ord = '{default: 3'd7};
    no = 0; pb = 0;
    for (int k = 0; k < 40 && no < 5; k++) begin
      all_in();
      cyc_a();
      if (ia.busy && !pb) begin
        ord[no] = ia.grant_id;
        no++;
      end
      pb = ia.busy;
      for (int r = 0; r < N; r++) if (acc[r]) bc[r] = (bc[r] == 1) ? 0 : bc[r] + 1;
      cyc_b();
    end
    chk("rr_order", 64'({ord[0], ord[1], ord[2], ord[3], ord[4]}), 64'({3'd0, 3'd1, 3'd2, 3'd3, 3'd0}));

    // async reset while the owner presents byte 2 of its packet
    t = 0;
    while (t < 20 && !(m_busy && bc[m_owner] == 1)) begin
      all_in();
      cyc_a();
      for (int r = 0; r < N; r++) if (acc[r]) bc[r] = (bc[r] == 1) ? 0 : bc[r] + 1;
      cyc_b();
      t++;
    end
    chk("rst_window", 64'(t < 20), 64'd1);
    all_in();
    #2;
    sys_rst = 1'b1;
    #1;
    chk("async_rst", 64'({ia.tx_valid, ia.busy, ia.req_ready, ia.grant_id, ia.tx_data}), 64'd0);
    m_reset();
    bc = '{default: 0};
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    all_in();
    cyc();
    cyc_a();
    chk("grant_after_rst", 64'({ia.busy, ia.grant_id}), 64'({1'b1, 3'd0}));
    cyc_b();

    // owner 3 stalls after one byte: release and pulse after 10 idle cycles, requester 0 next
    do_reset();
    ia.req_valid = 4'b1000; ia.req_data = 32'h3A00_0000; ia.req_last = 4'b0000; ia.tx_ready = 1'b1;
    cyc();
    cyc();
    ia.req_valid = 4'b0001; ia.req_last = 4'b0001; ia.req_data = 32'h0000_000B;
    repeat (10) cyc();
    cyc_a();
    chk("timeout_pulse", 64'({ia.timeout_pulse, ia.busy}), 64'(2'b10));
    cyc_b();
    cyc_a();
    chk("after_timeout", 64'({ia.busy, ia.grant_id, ia.tx_data}), 64'({1'b1, 3'd0, 8'h0B}));
    cyc_b();
    ia.req_valid = 4'b0000;
    cyc_a();
    chk("pulse_single", 64'({ia.timeout_pulse, ia.busy}), 64'(2'b00));
    cyc_b();

    // random traffic with pauses so timeouts happen, requesters obey valid/ready hold
    do_reset();
    rv = '0; rl = '0; rd = '{default: 8'h00}; pause = '{default: 0};
    repeat (2000) begin
      for (int r = 0; r < N; r++) begin
        if (rv[r] && !acc[r]) begin
        end else if (pause[r] > 0) begin
          pause[r]--; rv[r] = 1'b0;
        end else if ($urandom_range(7) == 0) begin
          pause[r] = $urandom_range(15); rv[r] = 1'b0;
        end else begin
          rv[r] = 1'b1; rd[r] = 8'($urandom); rl[r] = ($urandom_range(2) == 0);
        end
      end
      ia.req_valid = rv; ia.req_last = rl;
      ia.req_data = {rd[3], rd[2], rd[1], rd[0]};
      ia.tx_ready = ($urandom_range(3) != 0);
      cyc();
    end

    // timeout disabled: owner 1 stalls 1000 cycles and keeps the channel
    ib.req_valid = 4'b0010; ib.req_data = 32'h0000_5500; ib.req_last = 4'b0000; ib.tx_ready = 1'b1;
    @(posedge sys_clk);
    #1;
    @(negedge sys_clk);
    chk("b_byte", 64'({ib.tx_valid, ib.tx_data, ib.req_ready, ib.grant_id}), 64'({1'b1, 8'h55, 4'b0010, 3'd1}));
    @(posedge sys_clk);
    #1;
    ib.req_valid = 4'b0000;
    errs = 0;
    repeat (1000) begin
      @(negedge sys_clk);
      if (!ib.busy || ib.timeout_pulse || ib.tx_valid) errs++;
    end
    chk("b_no_timeout", 64'(errs), 64'd0);
    chk("b_still_owner", 64'({ib.busy, ib.grant_id}), 64'({1'b1, 3'd1}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
